// File: rtl/regfile_mp.sv
// Multi-read-port GPR file with byte-enabled writes, hardwired zero register,
// optional write->read bypass and a pending-write (busy) scoreboard.

module regfile_mp_rdport #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   stored,
   input  logic                busy_raw,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [DATA_W/8-1:0] wr_be,
   output logic [DATA_W-1:0]   data,
   output logic                busy
);
   logic is_zero;
   logic hit;

   always_comb begin
      is_zero = (ZERO_REG != 0) && (addr == '0);
      hit     = (BYPASS != 0) && wr_en && (wr_addr == addr) && !is_zero;
      data    = stored;
      for (int b = 0; b < DATA_W/8; b++) begin
         if (hit && wr_be[b]) data[b*8 +: 8] = wr_data[b*8 +: 8];
      end
      if (is_zero) data = '0;
      // a same-cycle release forwards the data, so the reader need not stall
      busy = busy_raw && !hit && !is_zero;
   end
endmodule

module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int N_READ   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                       clk,
   input  logic                       reset_i,
   input  logic [N_READ*ADDR_W-1:0]   rd_addr_i,
   output logic [N_READ*DATA_W-1:0]   rd_data_o,
   output logic [N_READ-1:0]          rd_busy_o,
   input  logic                       wr_en_i,
   input  logic [ADDR_W-1:0]          wr_addr_i,
   input  logic [DATA_W-1:0]          wr_data_i,
   input  logic [DATA_W/8-1:0]        wr_be_i,
   input  logic                       rsv_en_i,
   input  logic [ADDR_W-1:0]          rsv_addr_i,
   output logic                       rsv_ok_o
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] rf [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              wr_ok;

   assign wr_ok    = wr_en_i && !((ZERO_REG != 0) && (wr_addr_i == '0));
   assign rsv_ok_o = rsv_en_i && !busy[rsv_addr_i] && !((ZERO_REG != 0) && (rsv_addr_i == '0));

   always_ff @(posedge clk) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      end else if (wr_ok) begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (wr_be_i[b]) rf[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
         end
      end
   end

   // release first, then reserve, so a same-cycle reserve of that register wins
   always_ff @(posedge clk) begin
      if (reset_i) begin
         busy <= '0;
      end else begin
         if (wr_en_i)  busy[wr_addr_i]  <= 1'b0;
         if (rsv_ok_o) busy[rsv_addr_i] <= 1'b1;
      end
   end

   for (genvar k = 0; k < N_READ; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      assign addr = rd_addr_i[k*ADDR_W +: ADDR_W];

      regfile_mp_rdport #(
         .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
      ) u_port (
         .addr    (addr),
         .stored  (rf[addr]),
         .busy_raw(busy[addr]),
         .wr_en   (wr_en_i),
         .wr_addr (wr_addr_i),
         .wr_data (wr_data_i),
         .wr_be   (wr_be_i),
         .data    (rd_data_o[k*DATA_W +: DATA_W]),
         .busy    (rd_busy_o[k])
      );
   end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: stimulus pushes expected outputs, a negedge monitor pops and compares.
// Instance a has BYPASS=1, instance b has BYPASS=0; both see identical inputs.

module tb_regfile_mp;
   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data_a, rd_data_b;
   logic [1:0]  rd_busy_a, rd_busy_b;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic        rsv_ok_a, rsv_ok_b;

   int errors = 0;
   int checks = 0;

   string       q_name[$];
   int          q_sel[$];
   logic [31:0] q_exp[$];

   always #5 clk = ~clk;

   regfile_mp #(.BYPASS(1)) dut_a (
      .clk(clk), .reset_i(reset), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a),
      .rd_busy_o(rd_busy_a), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .wr_be_i(wr_be), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .rsv_ok_o(rsv_ok_a));

   regfile_mp #(.BYPASS(0)) dut_b (
      .clk(clk), .reset_i(reset), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
      .rd_busy_o(rd_busy_b), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .wr_be_i(wr_be), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .rsv_ok_o(rsv_ok_b));

   // sel: 0 a.port0 data, 1 a.port1 data, 2 a.busy, 3 a.rsv_ok, 4 b.port0 data, 5 b.busy
   function automatic void expect_v(string name, int sel, logic [31:0] v);
      q_name.push_back(name);
      q_sel.push_back(sel);
      q_exp.push_back(v);
   endfunction

   always @(negedge clk) begin
      while (q_sel.size() > 0) begin
         string       n;
         int          s;
         logic [31:0] e, act;
         n = q_name.pop_front();
         s = q_sel.pop_front();
         e = q_exp.pop_front();
         case (s)
            0:       act = rd_data_a[31:0];
            1:       act = rd_data_a[63:32];
            2:       act = {30'd0, rd_busy_a};
            3:       act = {31'd0, rsv_ok_a};
            4:       act = rd_data_b[31:0];
            default: act = {30'd0, rd_busy_b};
         endcase
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, e);
         end
      end
   end

   task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic re, input logic [4:0] ra,
                        input logic [4:0] r0, input logic [4:0] r1);
      @(posedge clk);
      #1;
      reset = rst; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
      rsv_en = re; rsv_addr = ra; rd_addr = {r1, r0};
   endtask

   task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, r0, r1);
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
      rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
      drive(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0);

      // 1: after reset every register reads 0, not busy
      for (int a = 0; a < 32; a++) begin
         idle(5'(a), 5'(31 - a));
         expect_v("reset_p0", 0, 32'h0);
         expect_v("reset_p1", 1, 32'h0);
         expect_v("reset_busy", 2, 32'h0);
         expect_v("reset_rsv_ok", 3, 32'h0);
      end

      // 2: full write, zero register
      drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 5'd5, 5'd5);
      expect_v("r5_bypass", 0, 32'hDEADBEEF);
      expect_v("r5_bypass_p1", 1, 32'hDEADBEEF);
      expect_v("r5_nobypass", 4, 32'h0);
      idle(5'd5, 5'd0);
      expect_v("r5_read", 0, 32'hDEADBEEF);
      expect_v("r0_read", 1, 32'h0);
      expect_v("r5_read_b", 4, 32'hDEADBEEF);
      drive(1'b0, 1'b1, 5'd0, 32'h1234, 4'hF, 1'b0, 5'd0, 5'd0, 5'd0);
      expect_v("r0_write_bypass", 0, 32'h0);
      idle(5'd0, 5'd0);
      expect_v("r0_after_write", 0, 32'h0);
      expect_v("r0_after_write_b", 4, 32'h0);

      // 3: byte-enabled merge
      drive(1'b0, 1'b1, 5'd7, 32'h11223344, 4'hF, 1'b0, 5'd0, 5'd7, 5'd7);
      expect_v("r7_init", 0, 32'h11223344);
      drive(1'b0, 1'b1, 5'd7, 32'hAABBCCDD, 4'b0101, 1'b0, 5'd0, 5'd7, 5'd5);
      expect_v("r7_merge_bypass", 0, 32'h11BB33DD);
      expect_v("r5_other_port", 1, 32'hDEADBEEF);
      expect_v("r7_merge_nobypass", 4, 32'h11223344);
      idle(5'd7, 5'd7);
      expect_v("r7_merge", 0, 32'h11BB33DD);
      expect_v("r7_merge_p1", 1, 32'h11BB33DD);
      expect_v("r7_merge_b", 4, 32'h11BB33DD);

      // 4: bypass vs stored; zero byte-enable changes nothing
      drive(1'b0, 1'b1, 5'd9, 32'h55, 4'hF, 1'b0, 5'd0, 5'd9, 5'd9);
      expect_v("r9_bypass", 0, 32'h55);
      expect_v("r9_nobypass", 4, 32'h0);
      idle(5'd9, 5'd9);
      expect_v("r9_next_b", 4, 32'h55);
      drive(1'b0, 1'b1, 5'd9, 32'hFFFFFFFF, 4'h0, 1'b0, 5'd0, 5'd9, 5'd9);
      expect_v("r9_be0_bypass", 0, 32'h55);
      idle(5'd9, 5'd9);
      expect_v("r9_be0", 0, 32'h55);
      expect_v("r9_be0_b", 4, 32'h55);

      // 5: reserve, double reserve, release
      drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3, 5'd3, 5'd3);
      expect_v("rsv3_ok", 3, 32'h1);
      expect_v("rsv3_busy_before", 2, 32'h0);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3, 5'd3, 5'd3);
      expect_v("rsv3_again_ok", 3, 32'h0);
      expect_v("rsv3_busy", 2, 32'h3);
      expect_v("rsv3_busy_b", 5, 32'h3);
      drive(1'b0, 1'b1, 5'd3, 32'h33, 4'hF, 1'b0, 5'd0, 5'd3, 5'd7);
      expect_v("rel3_busy_bypass", 2, 32'h0);
      expect_v("rel3_busy_nobypass", 5, 32'h1);
      expect_v("rel3_data", 0, 32'h33);
      idle(5'd3, 5'd3);
      expect_v("rel3_busy_after", 2, 32'h0);
      expect_v("rel3_busy_after_b", 5, 32'h0);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd0, 5'd0, 5'd0);
      expect_v("rsv0_ok", 3, 32'h0);
      idle(5'd0, 5'd0);
      expect_v("rsv0_busy", 2, 32'h0);

      // 6: same-cycle release and reserve; new reservation survives
      drive(1'b0, 1'b1, 5'd4, 32'h44, 4'hF, 1'b1, 5'd4, 5'd4, 5'd4);
      expect_v("relrsv4_ok", 3, 32'h1);
      expect_v("relrsv4_busy_now", 2, 32'h0);
      idle(5'd4, 5'd4);
      expect_v("relrsv4_busy", 2, 32'h3);
      expect_v("relrsv4_busy_b", 5, 32'h3);
      expect_v("relrsv4_data", 0, 32'h44);

      // reset while a reservation and write are requested wipes everything
      drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd6, 5'd6, 5'd6);
      expect_v("rsv6_ok", 3, 32'h1);
      drive(1'b1, 1'b1, 5'd11, 32'hCAFEF00D, 4'hF, 1'b1, 5'd10, 5'd6, 5'd11);
      idle(5'd6, 5'd11);
      expect_v("rst_r6", 0, 32'h0);
      expect_v("rst_r11", 1, 32'h0);
      expect_v("rst_busy_6_11", 2, 32'h0);
      expect_v("rst_r6_b", 4, 32'h0);
      idle(5'd4, 5'd10);
      expect_v("rst_busy_4_10", 2, 32'h0);
      expect_v("rst_busy_4_10_b", 5, 32'h0);
      idle(5'd5, 5'd7);
      expect_v("rst_r5", 0, 32'h0);
      expect_v("rst_r7", 1, 32'h0);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd4, 5'd4, 5'd4);
      expect_v("rsv4_after_rst", 3, 32'h1);

      @(negedge clk);
      #1;
      checks++;
      if (q_sel.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q_sel.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
